eth_link_speed_detect: RTL and testbench

//  Per-channel RGMII link speed detector for the multi-port 1G MAC. Runs in the MAC tx clock domain.
//  Per channel it measures toggles of an already-synchronised, prescaled rx clock bit against a local

---
 rtl/eth_link_speed_detect_if.sv | 33 +++
 rtl/eth_link_speed_detect.sv | 149 ++++++++++++++
 tb/tb_eth_link_speed_detect.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/eth_link_speed_detect_if.sv
// Link speed detector channel bundle.
// The bench drives it through master; the detector uses slave.
interface eth_link_speed_detect_if #(
  parameter int NUM_CH = 2
) ();
  logic [NUM_CH-1:0]   toggle_i;
  logic [NUM_CH-1:0]   force_en_i;
  logic [2*NUM_CH-1:0] force_speed_i;
  logic [2*NUM_CH-1:0] speed_o;
  logic [NUM_CH-1:0]   mii_select_o;
  logic [NUM_CH-1:0]   link_up_o;
  logic [NUM_CH-1:0]   speed_change_o;

  modport master (
    output toggle_i,
    output force_en_i,
    output force_speed_i,
    input  speed_o,
    input  mii_select_o,
    input  link_up_o,
    input  speed_change_o
  );

  modport slave (
    input  toggle_i,
    input  force_en_i,
    input  force_speed_i,
    output speed_o,
    output mii_select_o,
    output link_up_o,
    output speed_change_o
  );
endinterface

// File: rtl/eth_link_speed_detect.sv
// Per-channel RGMII link speed detector.
// Counts rx toggles per reference window and classifies 10M/100M/1000M.
module eth_link_speed_detect #(
  parameter int NUM_CH       = 2,
  parameter int WINDOW_W     = 7,
  parameter int EDGE_TARGET  = 3,
  parameter int THRESH_100   = 32,
  parameter int CONFIRM      = 2,
  parameter int IDLE_WINDOWS = 4
) (
  input  logic clk,
  input  logic rst,
  eth_link_speed_detect_if.slave lsd
);

  localparam int EW = $clog2(EDGE_TARGET + 1);
  localparam int CW = $clog2(CONFIRM + 1);
  localparam int IW = $clog2(IDLE_WINDOWS + 1);

  localparam logic [1:0] SPD_10  = 2'b00;
  localparam logic [1:0] SPD_100 = 2'b01;
  localparam logic [1:0] SPD_1G  = 2'b10;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic                prev_q;
    logic [WINDOW_W-1:0] ref_q, ref_d;
    logic [EW-1:0]       edge_q, edge_d;
    logic [1:0]          cand_q, cand_d;
    logic [CW-1:0]       conf_q, conf_d;
    logic [IW-1:0]       idle_q, idle_d;
    logic [1:0]          spd_q, spd_d;
    logic                link_q, link_d;
    logic                chg_q, chg_d;
    logic                mii_q;

    logic       tog;
    logic       edge_hit;
    logic       early;
    logic       expire;
    logic       dec_v;
    logic       idle_ev;
    logic       force_on;
    logic       conf_hit;
    logic       idle_drop;
    logic [1:0] dec;
    logic [1:0] fspd;

    always_comb begin
      tog      = lsd.toggle_i[c];
      force_on = lsd.force_en_i[c];
      edge_hit = tog ^ prev_q;
      early    = edge_q == EW'(EDGE_TARGET);
      expire   = (&ref_q) && !early;
      dec_v    = early || (expire && edge_q != '0);
      idle_ev  = expire && edge_q == '0;

      dec = SPD_10;
      if (early) begin
        dec = (ref_q >= WINDOW_W'(THRESH_100)) ? SPD_100 : SPD_1G;
      end

      // code 11 is not a valid speed; treat it as gigabit
      fspd = lsd.force_speed_i[2*c +: 2];
      if (fspd == 2'b11) begin
        fspd = SPD_1G;
      end

      ref_d  = ref_q + 1'b1;
      edge_d = edge_q + EW'(edge_hit);
      if (early || expire) begin
        ref_d  = '0;
        edge_d = '0;
      end

      cand_d = cand_q;
      conf_d = conf_q;
      idle_d = idle_q;
      if (dec_v) begin
        idle_d = '0;
        cand_d = dec;
        if (dec == cand_q) begin
          conf_d = (conf_q == CW'(CONFIRM)) ? conf_q : conf_q + 1'b1;
        end else begin
          conf_d = CW'(1);
        end
      end else if (idle_ev) begin
        conf_d = '0;
        if (idle_q != IW'(IDLE_WINDOWS)) begin
          idle_d = idle_q + 1'b1;
        end
      end

      conf_hit  = !force_on && dec_v && conf_d == CW'(CONFIRM);
      idle_drop = !force_on && idle_ev && idle_d == IW'(IDLE_WINDOWS);

      spd_d  = spd_q;
      link_d = link_q;
      chg_d  = 1'b0;
      unique case (1'b1)
        force_on: begin
          spd_d  = fspd;
          link_d = 1'b1;
          chg_d  = (fspd != spd_q) || !link_q;
        end
        conf_hit: begin
          spd_d  = dec;
          link_d = 1'b1;
          chg_d  = (dec != spd_q) || !link_q;
        end
        idle_drop: begin
          link_d = 1'b0;
        end
        default: ;
      endcase
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        prev_q <= tog;
        ref_q  <= '0;
        edge_q <= '0;
        cand_q <= SPD_10;
        conf_q <= '0;
        idle_q <= '0;
        spd_q  <= SPD_1G;
        link_q <= 1'b0;
        chg_q  <= 1'b0;
        mii_q  <= 1'b0;
      end else begin
        prev_q <= tog;
        ref_q  <= ref_d;
        edge_q <= edge_d;
        cand_q <= cand_d;
        conf_q <= conf_d;
        idle_q <= idle_d;
        spd_q  <= spd_d;
        link_q <= link_d;
        chg_q  <= chg_d;
        mii_q  <= spd_d != SPD_1G;
      end
    end

    assign lsd.speed_o[2*c +: 2]  = spd_q;
    assign lsd.mii_select_o[c]    = mii_q;
    assign lsd.link_up_o[c]       = link_q;
    assign lsd.speed_change_o[c]  = chg_q;
  end

endmodule

// File: tb/tb_eth_link_speed_detect.sv
// Directed bench for eth_link_speed_detect.
// Toggle edges are scripted window by window so every decision is exact.
module tb_eth_link_speed_detect;

  logic clk = 1'b0;
  logic rst;
  logic tog0;
  logic tog1;

  always #5 clk = ~clk;

  eth_link_speed_detect_if #(.NUM_CH(2)) lsd ();

  assign lsd.toggle_i = {tog1, tog0};

  eth_link_speed_detect #(
    .NUM_CH(2),
    .WINDOW_W(7),
    .EDGE_TARGET(3),
    .THRESH_100(32),
    .CONFIRM(2),
    .IDLE_WINDOWS(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .lsd(lsd)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int pc0 = 0;
  int pc1 = 0;

  always @(posedge clk) begin
    #1;
    pc0 <= pc0 + int'(lsd.speed_change_o[0]);
    pc1 <= pc1 + int'(lsd.speed_change_o[1]);
  end

  typedef struct {
    int         g;
    int         nexp;
    bit         fen;
    logic [1:0] fs;
    logic [1:0] spd;
    bit         lnk;
    bit         mii;
    int         pulses;
  } vec_t;

  vec_t vt[25];

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string nm, input int ch,
                         input int spd, input int lnk, input int mii);
    chk({nm, ".speed"}, int'(lsd.speed_o[2*ch +: 2]), spd);
    chk({nm, ".link"}, int'(lsd.link_up_o[ch]), lnk);
    chk({nm, ".mii"}, int'(lsd.mii_select_o[ch]), mii);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic flip(input int ch);
    if (ch == 0) tog0 = ~tog0;
    else         tog1 = ~tog1;
  endtask

  // three edges g cycles apart; early decision at local cycle 3g+1
  task automatic measure(input int ch, input int g);
    for (int k = 0; k < 3; k++) begin
      tick(g);
      flip(ch);
    end
    tick(2);
  endtask

  // n (<3) edges then let the full 128-cycle window expire
  task automatic expire(input int ch, input int n);
    for (int k = 0; k < n; k++) begin
      tick(10);
      flip(ch);
    end
    tick(128 - 10 * n);
  endtask

  task automatic do_reset();
    lsd.force_en_i    = 2'b00;
    lsd.force_speed_i = 4'b0000;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  initial begin
    int p0;
    int p1;

    vt[0]  = '{4,  0, 1'b0, 2'b00, 2'b10, 1'b0, 1'b0, 0};
    vt[1]  = '{4,  0, 1'b0, 2'b00, 2'b10, 1'b1, 1'b0, 1};
    vt[2]  = '{4,  0, 1'b0, 2'b00, 2'b10, 1'b1, 1'b0, 0};
    vt[3]  = '{40, 0, 1'b0, 2'b00, 2'b10, 1'b1, 1'b0, 0};
    vt[4]  = '{4,  0, 1'b0, 2'b00, 2'b10, 1'b1, 1'b0, 0};
    vt[5]  = '{4,  0, 1'b0, 2'b00, 2'b10, 1'b1, 1'b0, 0};
    vt[6]  = '{40, 0, 1'b0, 2'b00, 2'b10, 1'b1, 1'b0, 0};
    vt[7]  = '{40, 0, 1'b0, 2'b00, 2'b01, 1'b1, 1'b1, 1};
    vt[8]  = '{40, 0, 1'b0, 2'b00, 2'b01, 1'b1, 1'b1, 0};
    vt[9]  = '{0,  1, 1'b0, 2'b00, 2'b01, 1'b1, 1'b1, 0};
    vt[10] = '{0,  2, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 1};
    vt[11] = '{0,  0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 0};
    vt[12] = '{0,  1, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 0};
    vt[13] = '{0,  1, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 0};
    vt[14] = '{0,  0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 0};
    vt[15] = '{0,  0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 0};
    vt[16] = '{0,  0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 0};
    vt[17] = '{0,  0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 0};
    vt[18] = '{0,  0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 0};
    vt[19] = '{4,  0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 0};
    vt[20] = '{4,  0, 1'b0, 2'b00, 2'b10, 1'b1, 1'b0, 1};
    vt[21] = '{40, 0, 1'b1, 2'b11, 2'b10, 1'b1, 1'b0, 0};
    vt[22] = '{40, 0, 1'b1, 2'b01, 2'b01, 1'b1, 1'b1, 1};
    vt[23] = '{4,  0, 1'b0, 2'b00, 2'b01, 1'b1, 1'b1, 0};
    vt[24] = '{4,  0, 1'b0, 2'b00, 2'b10, 1'b1, 1'b0, 1};

    tog0 = 1'b0;
    tog1 = 1'b0;
    lsd.force_en_i    = 2'b00;
    lsd.force_speed_i = 4'b0000;
    rst = 1'b1;
    tick(3);
    chk_out("reset.ch0", 0, 2, 0, 0);
    chk_out("reset.ch1", 1, 2, 0, 0);
    chk("reset.chg", int'(lsd.speed_change_o), 0);
    rst = 1'b0;

    // table: ch0 scripted windows, ch1 held idle
    p1 = pc1;
    for (int i = 0; i < 25; i++) begin
      lsd.force_en_i[0]         = vt[i].fen;
      lsd.force_speed_i[1:0]    = vt[i].fs;
      p0 = pc0;
      if (vt[i].g > 0) measure(0, vt[i].g);
      else             expire(0, vt[i].nexp);
      chk_out($sformatf("row%0d", i), 0,
              int'(vt[i].spd), int'(vt[i].lnk), int'(vt[i].mii));
      chk($sformatf("row%0d.pulses", i), pc0 - p0, vt[i].pulses);
    end
    lsd.force_en_i[0] = 1'b0;
    chk_out("table.ch1", 1, 2, 0, 0);
    chk("table.ch1.pulses", pc1 - p1, 0);

    // link loss: drop exactly at the end of the fourth idle window
    do_reset();
    measure(0, 4);
    measure(0, 4);
    chk_out("loss.up", 0, 2, 1, 0);
    p0 = pc0;
    expire(0, 0);
    expire(0, 0);
    expire(0, 0);
    tick(127);
    chk("loss.before", int'(lsd.link_up_o[0]), 1);
    tick(1);
    chk_out("loss.after", 0, 2, 0, 0);
    chk("loss.pulses", pc0 - p0, 0);

    // both channels concurrently: ch0 at 100M, ch1 at 10M
    do_reset();
    p0 = pc0;
    p1 = pc1;
    fork
      begin
        repeat (3) measure(0, 40);
      end
      begin
        repeat (3) expire(1, 1);
      end
    join
    chk_out("multi.ch0", 0, 1, 1, 1);
    chk_out("multi.ch1", 1, 0, 1, 1);
    chk("multi.ch0.pulses", pc0 - p0, 1);
    chk("multi.ch1.pulses", pc1 - p1, 1);

    // force 11 while at 100M, then reset mid-window
    do_reset();
    measure(0, 40);
    measure(0, 40);
    chk_out("force.pre", 0, 1, 1, 1);
    tick(40);
    flip(0);
    tick(40);
    flip(0);
    lsd.force_en_i[0]      = 1'b1;
    lsd.force_speed_i[1:0] = 2'b11;
    tick(1);
    chk_out("force.now", 0, 2, 1, 0);
    chk("force.pulse", int'(lsd.speed_change_o[0]), 1);
    rst = 1'b1;
    tick(1);
    chk_out("midrst", 0, 2, 0, 0);
    chk("midrst.chg", int'(lsd.speed_change_o[0]), 0);
    rst = 1'b0;
    lsd.force_en_i[0] = 1'b0;
    p0 = pc0;
    measure(0, 4);
    chk("midrst.one", int'(lsd.link_up_o[0]), 0);
    measure(0, 4);
    chk_out("midrst.two", 0, 2, 1, 0);
    chk("midrst.pulses", pc0 - p0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
